// File: rtl/pingpong_buffer_scheduler.sv
// pingpong_buffer_scheduler: A/B bank fill/drain sequencer with address generation; define PINGPONG_STALL_CNT_EN for stall counters
module pingpong_buffer_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_last,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  drain_go,
  output logic                  mem_wr_en,
  output logic                  mem_wr_bank,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic                  mem_rd_bank,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [1:0]            bank_full
`ifdef PINGPONG_STALL_CNT_EN
  ,
  output logic [31:0]           stall_in_cnt,
  output logic [31:0]           stall_drain_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_e;
  typedef enum logic {D_IDLE, D_RUN} drain_e;
  bank_e                 bank_q [2];
  bank_e                 bank_d [2];
  logic [ADDR_WIDTH-1:0] last_q [2];
  logic [ADDR_WIDTH-1:0] last_d [2];
  drain_e                d_state_q, d_state_d;
  logic                  fill_ptr_q, fill_ptr_d;
  logic                  drain_ptr_q, drain_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  rd_final, start;

  assign in_ready    = bank_q[fill_ptr_q] == EMPTY || bank_q[fill_ptr_q] == FILLING;
  assign bank_full   = {bank_q[1] == FULL, bank_q[0] == FULL};
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_bank = wr_bank_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign mem_rd_en   = d_state_q == D_RUN;
  assign mem_rd_bank = drain_ptr_q;
  assign mem_rd_addr = rd_addr_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;

  // Next state: drain sequencing (with back-to-back chaining) and fill handshakes on the opposite bank
  always_comb begin
    bank_d      = bank_q;
    last_d      = last_q;
    fill_ptr_d  = fill_ptr_q;
    wr_cnt_d    = wr_cnt_q;
    wr_en_d     = 1'b0;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_final    = d_state_q == D_RUN && rd_addr_q == last_q[drain_ptr_q];
    drain_ptr_d = rd_final ? ~drain_ptr_q : drain_ptr_q;
    start       = drain_go && bank_q[drain_ptr_d] == FULL && (d_state_q == D_IDLE || rd_final);
    if (rd_final) bank_d[drain_ptr_q] = EMPTY;
    if (start) bank_d[drain_ptr_d] = DRAINING;
    d_state_d   = (start || (d_state_q == D_RUN && !rd_final)) ? D_RUN : D_IDLE;
    rd_addr_d   = start ? '0 : (d_state_q == D_RUN && !rd_final) ? rd_addr_q + ADDR_WIDTH'(1) : rd_addr_q;
    out_valid_d = d_state_q == D_RUN;
    out_last_d  = rd_final;
    if (in_valid && in_ready) begin
      wr_en_d   = 1'b1;
      wr_bank_d = fill_ptr_q;
      wr_addr_d = wr_cnt_q;
      wr_data_d = in_data;
      if (bank_q[fill_ptr_q] == EMPTY) last_d[fill_ptr_q] = cfg_last;
      if (wr_cnt_q == last_d[fill_ptr_q]) begin
        bank_d[fill_ptr_q] = FULL;
        fill_ptr_d         = ~fill_ptr_q;
        wr_cnt_d           = '0;
      end else begin
        bank_d[fill_ptr_q] = FILLING;
        wr_cnt_d           = wr_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  // State and registered outputs; reset drops any in-flight tile
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q      <= '{EMPTY, EMPTY};
      last_q      <= '{'0, '0};
      d_state_q   <= D_IDLE;
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
      wr_cnt_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      last_q      <= last_d;
      d_state_q   <= d_state_d;
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef PINGPONG_STALL_CNT_EN
  logic [31:0] stall_in_q, stall_drain_q;
  assign stall_in_cnt    = stall_in_q;
  assign stall_drain_cnt = stall_drain_q;

  // Saturating counts of producer stalls and drain requests with no full bank ready
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_in_q    <= '0;
      stall_drain_q <= '0;
    end else begin
      if (in_valid && !in_ready && ~&stall_in_q) stall_in_q <= stall_in_q + 32'd1;
      if (d_state_q == D_IDLE && drain_go && bank_q[drain_ptr_q] != FULL && ~&stall_drain_q)
        stall_drain_q <= stall_drain_q + 32'd1;
    end
  end
`endif
endmodule
